// File: rtl/fc8_cpu_core_v2.sv
// +--------------------------------------------------------------------+
// | fc8_cpu_core_v2 : multi-cycle FC8 8-bit CPU core with NMI/IRQ entry |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fc8_cpu_core_v2 #(
   parameter logic [15:0] RESET_PC     = 16'h8000,
   parameter logic [15:0] SP_INIT      = 16'h0100,
   parameter logic [15:0] SP_LIMIT     = 16'h01FF,
   parameter logic [15:0] NMI_VEC      = 16'hFFFA,
   parameter logic [15:0] IRQ_VEC      = 16'hFFFE,
   parameter logic        IRQ_MASK_RST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        we,
   input  logic        irq_n,
   input  logic        nmi_n,
   output logic        sync,
   output logic        int_ack,
   output logic        stack_ovf
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_OP1, S_OP2, S_MEM,
      S_INT0, S_INT1, S_INT2, S_INT3, S_INT4, S_INT5,
      S_RTI0, S_RTI1, S_RTI2, S_RTI3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, f_q, f_d;
   logic [15:0] sp_q, sp_d, pc_q, pc_d;
   logic [7:0]  opcode_q, opcode_d, lo_q, lo_d;
   logic [15:0] addr_q, addr_d, vec_q, vec_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        we_q, we_d, sync_q, sync_d, int_ack_q, int_ack_d;
   logic        stack_ovf_q, stack_ovf_d, nmi_pend_q, nmi_pend_d, nmi_hist_q, nmi_hist_d;

   logic [15:0] pc_inc, sp_inc, sp_dec;
   logic [7:0]  x_inc;

   assign addr      = addr_q;
   assign data_out  = data_out_q;
   assign we        = we_q;
   assign sync      = sync_q;
   assign int_ack   = int_ack_q;
   assign stack_ovf = stack_ovf_q;

   assign pc_inc = pc_q + 16'd1;
   assign sp_inc = sp_q + 16'd1;
   assign sp_dec = sp_q - 16'd1;
   assign x_inc  = x_q + 8'd1;

   // F layout: N at bit 7, I at bit 2, Z at bit 1, C at bit 0
   function automatic logic [7:0] set_nz(input logic [7:0] f, input logic [7:0] r);
      return {r[7], f[6:2], (r == 8'h00), f[0]};
   endfunction

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      x_d         = x_q;
      y_d         = y_q;
      f_d         = f_q;
      sp_d        = sp_q;
      pc_d        = pc_q;
      opcode_d    = opcode_q;
      lo_d        = lo_q;
      addr_d      = addr_q;
      vec_d       = vec_q;
      data_out_d  = data_out_q;
      we_d        = 1'b0;
      sync_d      = 1'b0;
      int_ack_d   = 1'b0;
      stack_ovf_d = stack_ovf_q;
      nmi_pend_d  = nmi_pend_q;
      nmi_hist_d  = nmi_n;

      case (state_q)
         S_FETCH: begin
            if (nmi_pend_q) begin
               nmi_pend_d = 1'b0;
               vec_d      = NMI_VEC;
               state_d    = S_INT0;
            end else if (!irq_n && !f_q[2]) begin
               vec_d   = IRQ_VEC;
               state_d = S_INT0;
            end else begin
               addr_d  = pc_q;
               sync_d  = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            opcode_d = data_in;
            pc_d     = pc_inc;
            addr_d   = pc_inc;
            state_d  = S_FETCH;
            case (data_in)
               8'hE8: begin
                  x_d = x_inc;
                  f_d = set_nz(f_q, x_inc);
               end
               8'h58: f_d[2] = 1'b0;
               8'h78: f_d[2] = 1'b1;
               8'hA9, 8'hA2, 8'hAD, 8'h8D, 8'h4C: state_d = S_OP1;
               8'h40: state_d = S_RTI0;
               default: ;
            endcase
         end
         S_OP1: begin
            pc_d = pc_inc;
            case (opcode_q)
               8'hA9: begin
                  a_d     = data_in;
                  f_d     = set_nz(f_q, data_in);
                  state_d = S_FETCH;
               end
               8'hA2: begin
                  x_d     = data_in;
                  f_d     = set_nz(f_q, data_in);
                  state_d = S_FETCH;
               end
               default: begin
                  lo_d    = data_in;
                  addr_d  = pc_inc;
                  state_d = S_OP2;
               end
            endcase
         end
         S_OP2: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            case (opcode_q)
               8'h4C: pc_d = {data_in, lo_q};
               8'hAD: begin
                  addr_d  = {data_in, lo_q};
                  state_d = S_MEM;
               end
               8'h8D: begin
                  addr_d     = {data_in, lo_q};
                  data_out_d = a_q;
                  we_d       = 1'b1;
                  state_d    = S_MEM;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (opcode_q == 8'hAD) begin
               a_d = data_in;
               f_d = set_nz(f_q, data_in);
            end
            state_d = S_FETCH;
         end
         S_INT0: begin
            addr_d     = sp_q;
            data_out_d = pc_q[15:8];
            we_d       = 1'b1;
            if (sp_q > SP_LIMIT) stack_ovf_d = 1'b1;
            state_d    = S_INT1;
         end
         S_INT1: begin
            sp_d       = sp_inc;
            addr_d     = sp_inc;
            data_out_d = pc_q[7:0];
            we_d       = 1'b1;
            if (sp_inc > SP_LIMIT) stack_ovf_d = 1'b1;
            state_d    = S_INT2;
         end
         S_INT2: begin
            sp_d       = sp_inc;
            addr_d     = sp_inc;
            data_out_d = f_q;
            we_d       = 1'b1;
            if (sp_inc > SP_LIMIT) stack_ovf_d = 1'b1;
            state_d    = S_INT3;
         end
         S_INT3: begin
            sp_d    = sp_inc;
            addr_d  = vec_q;
            f_d[2]  = 1'b1;
            state_d = S_INT4;
         end
         S_INT4: begin
            lo_d      = data_in;
            addr_d    = vec_q + 16'd1;
            int_ack_d = 1'b1;
            state_d   = S_INT5;
         end
         S_INT5: begin
            pc_d    = {data_in, lo_q};
            state_d = S_FETCH;
         end
         // Pulls overlap: each cycle consumes the byte addressed by the previous one
         S_RTI0: begin
            sp_d    = sp_dec;
            addr_d  = sp_dec;
            state_d = S_RTI1;
         end
         S_RTI1: begin
            f_d     = data_in & 8'h87;
            sp_d    = sp_dec;
            addr_d  = sp_dec;
            state_d = S_RTI2;
         end
         S_RTI2: begin
            lo_d    = data_in;
            sp_d    = sp_dec;
            addr_d  = sp_dec;
            state_d = S_RTI3;
         end
         S_RTI3: begin
            pc_d    = {data_in, lo_q};
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (nmi_hist_q && !nmi_n) nmi_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         a_q         <= 8'h00;
         x_q         <= 8'h00;
         y_q         <= 8'h00;
         f_q         <= {5'b0, IRQ_MASK_RST, 2'b00};
         sp_q        <= SP_INIT;
         pc_q        <= RESET_PC;
         opcode_q    <= 8'h00;
         lo_q        <= 8'h00;
         addr_q      <= 16'h0000;
         vec_q       <= 16'h0000;
         data_out_q  <= 8'h00;
         we_q        <= 1'b0;
         sync_q      <= 1'b0;
         int_ack_q   <= 1'b0;
         stack_ovf_q <= 1'b0;
         nmi_pend_q  <= 1'b0;
         nmi_hist_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         x_q         <= x_d;
         y_q         <= y_d;
         f_q         <= f_d;
         sp_q        <= sp_d;
         pc_q        <= pc_d;
         opcode_q    <= opcode_d;
         lo_q        <= lo_d;
         addr_q      <= addr_d;
         vec_q       <= vec_d;
         data_out_q  <= data_out_d;
         we_q        <= we_d;
         sync_q      <= sync_d;
         int_ack_q   <= int_ack_d;
         stack_ovf_q <= stack_ovf_d;
         nmi_pend_q  <= nmi_pend_d;
         nmi_hist_q  <= nmi_hist_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fc8_cpu_core_v2.sv
// +--------------------------------------------------------------------+
// | tb_fc8_cpu_core_v2 : directed bench for fc8_cpu_core_v2             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fc8_cpu_core_v2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n0, rst_n1, irq_n0, irq_n1, nmi_n0, nmi_n1;
   logic [15:0] addr0, addr1;
   logic [7:0]  din0, din1, dout0, dout1;
   logic        we0, we1, sync0, sync1, ack0, ack1, ovf0, ovf1;

   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem1 [0:65535];
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [7:0]  ld_data;

   int checks   = 0;
   int failures = 0;
   int we_cnt   = 0;
   int ack_cnt  = 0;
   logic [15:0] wr_a = 16'h0;
   logic [7:0]  wr_d = 8'h0;
   int we_base, ack_base;

   assign din0 = mem0[addr0];
   assign din1 = mem1[addr1];

   always @(posedge clk) begin
      if (ld_en) begin
         mem0[ld_addr] <= ld_data;
         mem1[ld_addr] <= ld_data;
      end else begin
         if (we0) mem0[addr0] <= dout0;
         if (we1) mem1[addr1] <= dout1;
      end
   end

   always @(posedge clk) begin
      if (we0) begin
         we_cnt <= we_cnt + 1;
         wr_a   <= addr0;
         wr_d   <= dout0;
      end
      if (ack0) ack_cnt <= ack_cnt + 1;
   end

   fc8_cpu_core_v2 dut0 (
      .clk(clk), .rst_n(rst_n0), .addr(addr0), .data_in(din0), .data_out(dout0),
      .we(we0), .irq_n(irq_n0), .nmi_n(nmi_n0), .sync(sync0), .int_ack(ack0),
      .stack_ovf(ovf0)
   );

   fc8_cpu_core_v2 #(.SP_LIMIT(16'h0101)) dut1 (
      .clk(clk), .rst_n(rst_n1), .addr(addr1), .data_in(din1), .data_out(dout1),
      .we(we1), .irq_n(irq_n1), .nmi_n(nmi_n1), .sync(sync1), .int_ack(ack1),
      .stack_ovf(ovf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic wait_sync0(input int max);
      int n = 0;
      while (!sync0 && n < max) begin
         tick();
         n++;
      end
      chk("sync0_wait", {31'b0, sync0}, 32'h1);
   endtask

   initial begin
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      irq_n0 = 1'b1; irq_n1 = 1'b1;
      nmi_n0 = 1'b1; nmi_n1 = 1'b1;
      ld_en = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;
      tick(); tick();

      // Reset state
      chk("rst_a",    {24'b0, dut0.a_q},  32'h00);
      chk("rst_x",    {24'b0, dut0.x_q},  32'h00);
      chk("rst_f",    {24'b0, dut0.f_q},  32'h04);
      chk("rst_sp",   {16'b0, dut0.sp_q}, 32'h0100);
      chk("rst_pc",   {16'b0, dut0.pc_q}, 32'h8000);
      chk("rst_addr", {16'b0, addr0},     32'h0000);
      chk("rst_we",   {31'b0, we0},       32'h0);
      chk("rst_sync", {31'b0, sync0},     32'h0);
      chk("rst_ack",  {31'b0, ack0},      32'h0);
      chk("rst_ovf",  {31'b0, ovf0},      32'h0);

      // LDA #00
      load(16'h8000, 8'hA9); load(16'h8001, 8'h00); load(16'h8002, 8'hEA);
      rst_n0 = 1'b1;
      chk("lda_imm_c0_sync", {31'b0, sync0}, 32'h0);
      tick();
      chk("lda_imm_c1_sync", {31'b0, sync0}, 32'h1);
      chk("lda_imm_c1_addr", {16'b0, addr0}, 32'h8000);
      tick();
      chk("lda_imm_c2_sync", {31'b0, sync0}, 32'h0);
      tick();
      chk("lda_imm_c3_sync", {31'b0, sync0}, 32'h0);
      tick();
      chk("lda_imm_c4_sync", {31'b0, sync0}, 32'h1);
      chk("lda_imm_c4_addr", {16'b0, addr0}, 32'h8002);
      chk("lda_imm_a",  {24'b0, dut0.a_q},  32'h00);
      chk("lda_imm_f",  {24'b0, dut0.f_q},  32'h06);
      chk("lda_imm_pc", {16'b0, dut0.pc_q}, 32'h8002);

      // LDA abs, STA abs, JMP
      rst_n0 = 1'b0;
      load(16'h8000, 8'hAD); load(16'h8001, 8'h34); load(16'h8002, 8'h12);
      load(16'h8003, 8'h8D); load(16'h8004, 8'h00); load(16'h8005, 8'h02);
      load(16'h8006, 8'h4C); load(16'h8007, 8'h00); load(16'h8008, 8'h90);
      load(16'h1234, 8'h80); load(16'h0200, 8'h00); load(16'h9000, 8'hEA);
      we_base = we_cnt;
      rst_n0 = 1'b1;
      repeat (5) tick();
      chk("lda_abs_a", {24'b0, dut0.a_q}, 32'h80);
      chk("lda_abs_f", {24'b0, dut0.f_q}, 32'h84);
      repeat (6) tick();
      chk("jmp_sync",  {31'b0, sync0},  32'h1);
      chk("jmp_saddr", {16'b0, addr0},  32'h8006);
      repeat (4) tick();
      chk("jmp_pc",    {16'b0, dut0.pc_q}, 32'h9000);
      chk("jmp_sync2", {31'b0, sync0},     32'h1);
      chk("jmp_addr2", {16'b0, addr0},     32'h9000);
      chk("sta_we_cycles", we_cnt - we_base, 32'd1);
      chk("sta_wr_addr", {16'b0, wr_a}, 32'h0200);
      chk("sta_wr_data", {24'b0, wr_d}, 32'h80);
      chk("sta_mem",     {24'b0, mem0[16'h0200]}, 32'h80);

      // CLI then IRQ entry, then RTI
      rst_n0 = 1'b0;
      irq_n0 = 1'b0;
      load(16'h8000, 8'h58); load(16'h8001, 8'hEA);
      load(16'hFFFE, 8'h00); load(16'hFFFF, 8'hA0); load(16'hA000, 8'h40);
      load(16'h0100, 8'hFF); load(16'h0101, 8'hFF); load(16'h0102, 8'hFF);
      ack_base = ack_cnt;
      rst_n0 = 1'b1;
      repeat (7) tick();
      chk("irq_ack_c7", {31'b0, ack0}, 32'h0);
      tick();
      chk("irq_ack_c8", {31'b0, ack0}, 32'h1);
      chk("irq_ack_addr", {16'b0, addr0}, 32'hFFFF);
      tick();
      chk("irq_ack_c9", {31'b0, ack0}, 32'h0);
      chk("irq_ack_cnt", ack_cnt - ack_base, 32'd1);
      chk("irq_sp",  {16'b0, dut0.sp_q}, 32'h0103);
      chk("irq_f",   {24'b0, dut0.f_q},  32'h04);
      chk("irq_pc",  {16'b0, dut0.pc_q}, 32'hA000);
      chk("irq_push_pch", {24'b0, mem0[16'h0100]}, 32'h80);
      chk("irq_push_pcl", {24'b0, mem0[16'h0101]}, 32'h01);
      chk("irq_push_f",   {24'b0, mem0[16'h0102]}, 32'h00);
      irq_n0 = 1'b1;
      tick();
      chk("rti_sync_addr", {16'b0, addr0}, 32'hA000);
      tick();
      wait_sync0(12);
      chk("rti_addr", {16'b0, addr0},     32'h8001);
      chk("rti_pc",   {16'b0, dut0.pc_q}, 32'h8001);
      chk("rti_f",    {24'b0, dut0.f_q},  32'h00);
      chk("rti_sp",   {16'b0, dut0.sp_q}, 32'h0100);

      // NMI during LDA abs beats a pending IRQ; held-low NMI does not retrigger
      rst_n0 = 1'b0;
      load(16'h8000, 8'h58); load(16'h8001, 8'hAD); load(16'h8002, 8'h34);
      load(16'h8003, 8'h12); load(16'h8004, 8'hEA); load(16'h1234, 8'h5A);
      load(16'hFFFA, 8'h00); load(16'hFFFB, 8'hB0);
      for (int i = 0; i < 32; i++) load(16'hB000 + 16'(i), 8'hEA);
      ack_base = ack_cnt;
      rst_n0 = 1'b1;
      repeat (4) tick();
      irq_n0 = 1'b0;
      nmi_n0 = 1'b0;
      repeat (10) tick();
      chk("nmi_pc", {16'b0, dut0.pc_q}, 32'hB000);
      chk("nmi_sp", {16'b0, dut0.sp_q}, 32'h0103);
      chk("nmi_a",  {24'b0, dut0.a_q},  32'h5A);
      chk("nmi_f",  {24'b0, dut0.f_q},  32'h04);
      chk("nmi_push_pch", {24'b0, mem0[16'h0100]}, 32'h80);
      chk("nmi_push_pcl", {24'b0, mem0[16'h0101]}, 32'h04);
      chk("nmi_push_f",   {24'b0, mem0[16'h0102]}, 32'h00);
      chk("nmi_ack_cnt", ack_cnt - ack_base, 32'd1);
      repeat (24) tick();
      chk("nmi_hold_sp",  {16'b0, dut0.sp_q}, 32'h0103);
      chk("nmi_hold_ack", ack_cnt - ack_base, 32'd1);
      nmi_n0 = 1'b1;
      irq_n0 = 1'b1;
      rst_n0 = 1'b0;

      // Stack overflow with SP_LIMIT=0101, then reset during INT1
      load(16'h8000, 8'hEA); load(16'h8001, 8'hEA); load(16'h8002, 8'hEA);
      load(16'h0104, 8'h55);
      rst_n1 = 1'b1;
      nmi_n1 = 1'b0;
      repeat (5) tick();
      chk("ovf_before_3rd", {31'b0, ovf1}, 32'h0);
      tick();
      chk("ovf_at_3rd",     {31'b0, ovf1}, 32'h1);
      chk("ovf_3rd_we",     {31'b0, we1},  32'h1);
      chk("ovf_3rd_addr",   {16'b0, addr1}, 32'h0102);
      nmi_n1 = 1'b1;
      repeat (3) tick();
      nmi_n1 = 1'b0;
      repeat (4) tick();
      chk("int1_we",   {31'b0, we1},   32'h1);
      chk("int1_addr", {16'b0, addr1}, 32'h0103);
      rst_n1 = 1'b0;
      nmi_n1 = 1'b1;
      tick();
      chk("rst_int_we",  {31'b0, we1},       32'h0);
      chk("rst_int_sp",  {16'b0, dut1.sp_q}, 32'h0100);
      chk("rst_int_ovf", {31'b0, ovf1},      32'h0);
      chk("rst_int_pc",  {16'b0, dut1.pc_q}, 32'h8000);
      rst_n1 = 1'b1;
      repeat (6) tick();
      chk("rst_int_pch_written", {24'b0, mem1[16'h0103]}, 32'hB0);
      chk("rst_int_no_pcl",      {24'b0, mem1[16'h0104]}, 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
